// File: rtl/pipe_exe_mdu_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_exe_mdu_if
//  Purpose  : EX-stage <-> multiply/divide unit handshake and result bundle.
//  Revision : 1.0
// ============================================================================
interface pipe_exe_mdu_if;
    logic        estart;
    logic [1:0]  eop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [4:0]  ern;
    logic        ewreg;
    logic        eflush;
    logic        stall;
    logic        mdone;
    logic [31:0] mres;
    logic [4:0]  mrn;
    logic        mwreg;

    modport master (
        output estart, eop, ea, eb, ern, ewreg, eflush,
        input  stall, mdone, mres, mrn, mwreg
    );

    modport slave (
        input  estart, eop, ea, eb, ern, ewreg, eflush,
        output stall, mdone, mres, mrn, mwreg
    );
endinterface
`default_nettype wire

// File: rtl/pipe_exe_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_exe_mdu
//  Purpose  : Iterative 32-bit unsigned MUL/MULHU/DIVU/REMU for the EX stage.
//             Divider present only when MDU_DIV_EN is defined.
//  Revision : 1.0
// ============================================================================
module pipe_exe_mdu (
    input  logic           clk,
    input  logic           clr,
    pipe_exe_mdu_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        sel_hi;
    logic [31:0] b;
    logic [4:0]  rn;
    logic        wreg;
    // hi:lo is the 64-bit product for multiplies, remainder:quotient for divides
    logic [32:0] hi;
    logic [31:0] lo;
    logic [32:0] hi_n;
    logic [31:0] lo_n;
    logic [32:0] mul_sum;
    logic        start;
`ifdef MDU_DIV_EN
    logic        is_div;
    logic [32:0] div_sh;
    logic [33:0] div_diff;
`endif

    assign start     = (state == IDLE) && bus.estart && !bus.eflush;
    assign bus.stall = !clr && (start || (state == BUSY));
    assign bus.mdone = (state == DONE);

    always_comb begin
        mul_sum = hi + (lo[0] ? {1'b0, b} : 33'd0);
        hi_n    = {1'b0, mul_sum[32:1]};
        lo_n    = {mul_sum[0], lo[31:1]};
`ifdef MDU_DIV_EN
        // Restoring step; b==0 naturally yields all-ones quotient and rem=ea
        div_sh   = {hi[31:0], lo[31]};
        div_diff = {1'b0, div_sh} - {2'b00, b};
        if (is_div) begin
            hi_n = div_diff[33] ? div_sh : div_diff[32:0];
            lo_n = {lo[30:0], ~div_diff[33]};
        end
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            sel_hi   <= 1'b0;
            b        <= 32'd0;
            rn       <= 5'd0;
            wreg     <= 1'b0;
            hi       <= 33'd0;
            lo       <= 32'd0;
            bus.mres <= 32'd0;
            bus.mrn  <= 5'd0;
            bus.mwreg <= 1'b0;
`ifdef MDU_DIV_EN
            is_div   <= 1'b0;
`endif
        end else if (bus.eflush) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.estart) begin
                        sel_hi <= bus.eop[0];
                        b      <= bus.eb;
                        rn     <= bus.ern;
                        wreg   <= bus.ewreg;
                        hi     <= 33'd0;
                        lo     <= bus.ea;
                        cnt    <= 5'd0;
`ifdef MDU_DIV_EN
                        is_div <= bus.eop[1];
                        state  <= BUSY;
`else
                        if (bus.eop[1]) begin
                            bus.mres  <= 32'd0;
                            bus.mrn   <= bus.ern;
                            bus.mwreg <= bus.ewreg;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`endif
                    end
                end
                BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        // MULHU/REMU take the upper half, MUL/DIVU the lower
                        bus.mres  <= sel_hi ? hi_n[31:0] : lo_n;
                        bus.mrn   <= rn;
                        bus.mwreg <= wreg;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pipe_exe_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_exe_mdu
//  Purpose  : Self-checking bench for pipe_exe_mdu (directed + random ops).
//  Revision : 1.0
// ============================================================================
module tb_pipe_exe_mdu;
    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   fails = 0;

    pipe_exe_mdu_if bus ();
    pipe_exe_mdu dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
`ifdef MDU_DIV_EN
            2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
`else
            default: return 32'd0;
`endif
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op);
`ifdef MDU_DIV_EN
        return 33;
`else
        return op[1] ? 1 : 33;
`endif
    endfunction

    // Called #1 after a rising edge with the unit idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rn, input logic wreg);
        int k = 0;
        int stalls;
        logic [31:0] exp;
        exp        = model(op, a, b);
        bus.estart = 1'b1;
        bus.eop    = op;
        bus.ea     = a;
        bus.eb     = b;
        bus.ern    = rn;
        bus.ewreg  = wreg;
        #1;
        stalls = bus.stall ? 1 : 0;
        while (!bus.mdone && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (bus.stall) stalls++;
        end
        check({tag, "/latency"}, k, latency(op));
        check({tag, "/stall_cycles"}, stalls, latency(op));
        check({tag, "/stall_in_done"}, {31'd0, bus.stall}, 32'd0);
        check({tag, "/mres"}, bus.mres, exp);
        check({tag, "/mrn"}, {27'd0, bus.mrn}, {27'd0, rn});
        check({tag, "/mwreg"}, {31'd0, bus.mwreg}, {31'd0, wreg});
        bus.estart = 1'b0;
        bus.ea     = $urandom;
        bus.eb     = $urandom;
        @(posedge clk);
        #1;
        check({tag, "/mdone_one_cycle"}, {31'd0, bus.mdone}, 32'd0);
        check({tag, "/mres_hold"}, bus.mres, exp);
    endtask

    initial begin
        int seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.estart = 1'b1;
        bus.eflush = 1'b0;
        bus.eop    = 2'd0;
        bus.ea     = 32'd7;
        bus.eb     = 32'd6;
        bus.ern    = 5'd0;
        bus.ewreg  = 1'b0;
        clr        = 1'b1;
        #2;
        check("reset/stall", {31'd0, bus.stall}, 32'd0);
        check("reset/mdone", {31'd0, bus.mdone}, 32'd0);
        check("reset/mres", bus.mres, 32'd0);
        check("reset/mrn", {27'd0, bus.mrn}, 32'd0);
        check("reset/mwreg", {31'd0, bus.mwreg}, 32'd0);
        @(posedge clk);
        #1;
        clr        = 1'b0;
        bus.estart = 1'b0;
        @(posedge clk);
        #1;

        run_op("mul_7x6", 2'd0, 32'd7, 32'd6, 5'd3, 1'b1);
        check("mul_7x6/const", bus.mres, 32'd42);
        run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0);
        run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1);
        check("mul_ff/const", bus.mres, 32'h0000_0001);
        run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 5'd5, 1'b1);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 5'd5, 1'b1);
        run_op("divu_5_0", 2'd2, 32'd5, 32'd0, 5'd6, 1'b1);
        run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 5'd7, 1'b0);

        // Flush mid-multiply, with estart still high so flush must also block restart
        bus.estart = 1'b1;
        bus.eop    = 2'd0;
        bus.ea     = 32'd123;
        bus.eb     = 32'd456;
        repeat (10) @(posedge clk);
        #1;
        bus.eflush = 1'b1;
        @(posedge clk);
        #1;
        check("flush/stall_c11", {31'd0, bus.stall}, 32'd0);
        check("flush/mdone_c11", {31'd0, bus.mdone}, 32'd0);
        @(posedge clk);
        #1;
        check("flush/no_restart", {31'd0, bus.stall}, 32'd0);
        bus.eflush = 1'b0;
        bus.estart = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus.mdone) seen++;
        end
        check("flush/no_mdone", seen, 0);
        run_op("after_flush", 2'd0, 32'd3, 32'd4, 5'd12, 1'b1);

        // Reset in the middle of a divide
        bus.estart = 1'b1;
        bus.eop    = 2'd2;
        bus.ea     = 32'd50;
        bus.eb     = 32'd7;
        repeat (20) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("midclr/stall", {31'd0, bus.stall}, 32'd0);
        check("midclr/mdone", {31'd0, bus.mdone}, 32'd0);
        check("midclr/mres", bus.mres, 32'd0);
        check("midclr/mrn", {27'd0, bus.mrn}, 32'd0);
        check("midclr/mwreg", {31'd0, bus.mwreg}, 32'd0);
        @(posedge clk);
        #1;
        clr        = 1'b0;
        bus.estart = 1'b0;
        @(posedge clk);
        #1;
        run_op("divu_9_3", 2'd2, 32'd9, 32'd3, 5'd2, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run_op($sformatf("rand%0d", i), rop, ra, rb, 5'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pipe_exe_mdu.md
PIPE_EXE_MDU -- requirements
Module: pipe_exe_mdu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have port clr, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port estart, input, 1 bit: EX-stage instruction is a multiply/divide op; held high by upstream while stall=1.
REQ-004 SHALL have port eop, input, 2 bits: operation select; 00=MUL (low product), 01=MULHU (high product), 10=DIVU (quotient), 11=REMU (remainder); all unsigned.
REQ-005 SHALL have ports ea and eb, input, 32 bits each: operands (dividend/divisor for div ops).
REQ-006 SHALL have port ern, input, 5 bits: destination register; and port ewreg, input, 1 bit: register-write enable.
REQ-007 SHALL have port eflush, input, 1 bit: abort the current operation.
REQ-008 SHALL have port stall, output, 1 bit: freezes PC, IF/ID and ID/EX registers.
REQ-009 SHALL have port mdone, output, 1 bit: one-cycle result-valid strobe for EX/MEM capture.
REQ-010 SHALL have ports mres (32 bits), mrn (5 bits) and mwreg (1 bit), outputs: result, latched ern, latched ewreg.

Function
REQ-011 SHALL implement FSM IDLE/BUSY/DONE with a 5-bit iteration counter.
REQ-012 IDLE: estart=1 and eflush=0 latches ea, eb, eop, ern, ewreg and moves to BUSY with counter=0.
REQ-013 BUSY: one radix-2 step per cycle; counter wraps 31->0 and moves to DONE.
REQ-014 DONE lasts exactly one cycle, then returns to IDLE; estart is ignored in DONE.
REQ-015 stall SHALL be combinational: (IDLE & estart & ~eflush) | BUSY; it is 0 in DONE.
REQ-016 Latency: stall high for 33 cycles (start cycle plus 32 BUSY cycles); mdone=1 in the cycle after the last BUSY cycle.
REQ-017 MUL/MULHU SHALL use a shift-add 64-bit product; mres is bits [31:0] for MUL and bits [63:32] for MULHU.
REQ-018 DIVU/REMU SHALL use restoring division with a 33-bit partial remainder.
REQ-019 Divide by zero: quotient=0xFFFFFFFF and remainder=ea, both at normal latency.
REQ-020 mres, mrn and mwreg SHALL be valid and stable while mdone=1, and hold their last values otherwise.
REQ-021 eflush in any state SHALL force IDLE on the next edge with no mdone.
REQ-022 When eflush and estart are both 1 in IDLE, flush SHALL win: no start, and stall=0.

Reset
REQ-023 clr=1 SHALL immediately force IDLE, counter=0, mdone=0, mres=0, mrn=0, mwreg=0 and all internal datapath registers to 0.
REQ-024 stall=0 while clr=1.
REQ-025 Reset mid-operation SHALL discard the operation; the first start after clr falls behaves per REQ-016.

Configuration
REQ-026 Macro MDU_DIV_EN defined: DIVU/REMU SHALL be implemented per REQ-018 and REQ-019.
REQ-027 MDU_DIV_EN undefined: the divider SHALL be removed; DIVU/REMU SHALL go from IDLE directly to DONE (stall high for 1 cycle) with mres=0; MUL/MULHU are unchanged.

Verification
REQ-028 MUL with ea=7, eb=6 -> stall=1 for cycles 0..32; mdone=1 in cycle 33; mres=42.
REQ-029 MULHU with ea=0xFFFFFFFF, eb=0xFFFFFFFF -> mres=0xFFFFFFFE; MUL with the same operands -> mres=0x00000001.
REQ-030 DIVU 100/7 -> mres=14; REMU 100/7 -> mres=2; ern=5, ewreg=1 -> mrn=5, mwreg=1 at mdone.
REQ-031 DIVU 5/0 -> mres=0xFFFFFFFF; REMU 5/0 -> mres=5 (with MDU_DIV_EN); both -> mres=0 after 1 stall cycle (without MDU_DIV_EN).
REQ-032 Start MUL, then assert eflush in cycle 10 -> IDLE in cycle 11, stall=0, no mdone; a following start completes normally.
REQ-033 Assert clr in cycle 20 of a DIVU -> outputs are 0 immediately; after clr falls, a DIVU 9/3 -> mres=3 at cycle 33.
